// File: rtl/cache_pkg.sv
// Shared cache definitions: FSM states, default cacheable limit, and
// address field extraction. The L1I successor uses the same helpers.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_CHECK  = 3'd2,
    ST_FILL   = 3'd3,
    ST_WRITE  = 3'd4
  } cache_state_e;

  localparam logic [31:0] CACHE_LIMIT_DEF = 32'h0080_0000;

  // word offset inside a line
  function automatic logic [31:0] get_offset(input logic [31:0] a, input int ob);
    return a & ((32'd1 << ob) - 32'd1);
  endfunction

  // line index
  function automatic logic [31:0] get_index(input logic [31:0] a, input int ib, input int ob);
    return (a >> ob) & ((32'd1 << ib) - 32'd1);
  endfunction

  // tag, taken only from the cached address bits
  function automatic logic [31:0] get_tag(input logic [31:0] a, input int ab, input int ib,
                                          input int ob);
    return (a >> (ib + ob)) & ((32'd1 << (ab - ib - ob)) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_sram.sv
// Single-port RAM with registered read, shaped so synthesis infers block RAM.
// Read-before-write: a write cycle returns the old contents.
module cache_sram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // memory write and registered read on the same address
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1d_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with
// burst line fill. Addresses at or above CACHE_LIMIT bypass the cache.
//
// state  | meaning
// IDLE   | waiting for a new cached request
// LOOKUP | tag/data RAM read of the latched address
// CHECK  | hit/miss decision, read hit completes here
// FILL   | fetching line words 0..N-1 from SDRAM
// WRITE  | write-through to SDRAM, update word on hit
module l1d_cache_wt
  import cache_pkg::*;
#(
  parameter int          ADDR_BITS   = 24,
  parameter int          INDEX_BITS  = 10,
  parameter int          OFFSET_BITS = 0,
  parameter logic [31:0] CACHE_LIMIT = CACHE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cache_reset,
  input  logic [31:0] l2_addr,
  input  logic [31:0] l2_data,
  input  logic        l2_we,
  input  logic        l2_start,
  output logic [31:0] l2_q,
  output logic        l2_done,
  output logic [31:0] sdc_addr,
  output logic [31:0] sdc_data,
  output logic        sdc_we,
  output logic        sdc_start,
  input  logic [31:0] sdc_q,
  input  logic        sdc_done
);

  localparam int          TAG_BITS  = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int          NLINES    = 1 << INDEX_BITS;
  localparam int          DATA_AW   = INDEX_BITS + OFFSET_BITS;
  localparam logic [3:0]  LAST_WORD = 4'((1 << OFFSET_BITS) - 1);
  localparam logic [31:0] OFF_MASK  = 32'((1 << OFFSET_BITS) - 1);

  cache_state_e          state_q, state_d;
  logic [31:0]           addr_q, addr_d, data_q, data_d;
  logic                  we_q, we_d, hit_q, hit_d, kill_q, kill_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  start_prev_q, start_prev_d;
  logic [31:0]           addr_prev_q, addr_prev_d;
  logic [NLINES-1:0]     valid_q, valid_d;
  logic [31:0]           l2_q_q, l2_q_d;
  logic                  l2_done_q, l2_done_d;
  logic [31:0]           sdc_addr_q, sdc_addr_d, sdc_data_q, sdc_data_d;
  logic                  sdc_we_q, sdc_we_d, sdc_start_q, sdc_start_d;

  logic                  pass, accept, hit;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag, tag_rd;
  logic [3:0]            req_off;
  logic [31:0]           fill_addr, dram_word;
  logic                  dram_we, tram_we;
  logic [31:0]           dram_wdata, dram_rdata;

  assign pass      = l2_addr >= CACHE_LIMIT;
  assign idx       = INDEX_BITS'(get_index(addr_q, INDEX_BITS, OFFSET_BITS));
  assign tag       = TAG_BITS'(get_tag(addr_q, ADDR_BITS, INDEX_BITS, OFFSET_BITS));
  assign req_off   = 4'(get_offset(addr_q, OFFSET_BITS));
  assign fill_addr = (addr_q & ~OFF_MASK) | 32'(cnt_q);
  assign dram_word = (state_q == ST_FILL) ? fill_addr : addr_q;
  assign hit       = valid_q[idx] && (tag_rd == tag);

  cache_sram #(.WIDTH(32), .DEPTH(1 << DATA_AW)) u_data (
    .clk   (clk),
    .we    (dram_we),
    .addr  (DATA_AW'(dram_word)),
    .wdata (dram_wdata),
    .rdata (dram_rdata)
  );

  cache_sram #(.WIDTH(TAG_BITS), .DEPTH(NLINES)) u_tag (
    .clk   (clk),
    .we    (tram_we),
    .addr  (idx),
    .wdata (tag),
    .rdata (tag_rd)
  );

  // next-state, RAM control and registered output computation
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    hit_d        = hit_q;
    kill_d       = kill_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    l2_q_d       = l2_q_q;
    l2_done_d    = 1'b0;
    sdc_addr_d   = sdc_addr_q;
    sdc_data_d   = sdc_data_q;
    sdc_we_d     = sdc_we_q;
    sdc_start_d  = sdc_start_q;
    start_prev_d = l2_start;
    addr_prev_d  = l2_addr;
    dram_we      = 1'b0;
    dram_wdata   = sdc_q;
    tram_we      = 1'b0;
    // a held strobe re-arms when the CPU moves from an uncached address
    accept = (state_q == ST_IDLE) && !pass && l2_start &&
             (!start_prev_q || (addr_prev_q >= CACHE_LIMIT));

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = l2_addr;
          data_d  = l2_data;
          we_d    = l2_we;
          kill_d  = 1'b0;
          cnt_d   = 4'd0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_CHECK;
      ST_CHECK: begin
        hit_d = hit;
        if (we_q) begin
          sdc_addr_d  = addr_q;
          sdc_data_d  = data_q;
          sdc_we_d    = 1'b1;
          sdc_start_d = 1'b1;
          state_d     = ST_WRITE;
        end else if (hit) begin
          l2_q_d    = dram_rdata;
          l2_done_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          sdc_addr_d  = fill_addr;
          sdc_we_d    = 1'b0;
          sdc_start_d = 1'b1;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (sdc_start_q) begin
          if (sdc_done) begin
            sdc_start_d = 1'b0;
            sdc_addr_d  = 32'd0;
            dram_we     = 1'b1;
            if (cnt_q == req_off) l2_q_d = sdc_q;
            if (cnt_q == LAST_WORD) begin
              tram_we   = 1'b1;
              if (!kill_q) valid_d[idx] = 1'b1;
              l2_done_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end else begin
          // one idle cycle between burst words, then the next word
          sdc_addr_d  = fill_addr;
          sdc_start_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (sdc_done) begin
          sdc_addr_d  = 32'd0;
          sdc_data_d  = 32'd0;
          sdc_we_d    = 1'b0;
          sdc_start_d = 1'b0;
          if (hit_q) begin
            dram_we    = 1'b1;
            dram_wdata = data_q;
          end
          l2_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // invalidate-all wins over a fill completing in the same cycle
    if (cache_reset) begin
      valid_d = '0;
      if (state_q != ST_IDLE) kill_d = 1'b1;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      we_q         <= 1'b0;
      hit_q        <= 1'b0;
      kill_q       <= 1'b0;
      cnt_q        <= 4'd0;
      valid_q      <= '0;
      l2_q_q       <= 32'd0;
      l2_done_q    <= 1'b0;
      sdc_addr_q   <= 32'd0;
      sdc_data_q   <= 32'd0;
      sdc_we_q     <= 1'b0;
      sdc_start_q  <= 1'b0;
      start_prev_q <= 1'b0;
      addr_prev_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      hit_q        <= hit_d;
      kill_q       <= kill_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      l2_q_q       <= l2_q_d;
      l2_done_q    <= l2_done_d;
      sdc_addr_q   <= sdc_addr_d;
      sdc_data_q   <= sdc_data_d;
      sdc_we_q     <= sdc_we_d;
      sdc_start_q  <= sdc_start_d;
      start_prev_q <= start_prev_d;
      addr_prev_q  <= addr_prev_d;
    end
  end

  assign sdc_addr  = pass ? l2_addr  : sdc_addr_q;
  assign sdc_data  = pass ? l2_data  : sdc_data_q;
  assign sdc_we    = pass ? l2_we    : sdc_we_q;
  assign sdc_start = pass ? l2_start : sdc_start_q;
  assign l2_q      = pass ? sdc_q    : l2_q_q;
  assign l2_done   = pass ? sdc_done : l2_done_q;

endmodule

// File: tb/tb_l1d_cache_wt.sv
// Bench for l1d_cache_wt with 4-word lines: CPU driver, SDRAM responder,
// line-level cache model and a golden memory for expected read data.
module tb_l1d_cache_wt;

  localparam int          OFF   = 2;
  localparam int          LW    = 1 << OFF;
  localparam logic [31:0] LIMIT = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        reset, cache_reset;
  logic [31:0] l2_addr, l2_data, l2_q;
  logic        l2_we, l2_start, l2_done;
  logic [31:0] sdc_addr, sdc_data, sdc_q;
  logic        sdc_we, sdc_start, sdc_done;

  always #5 clk = ~clk;

  l1d_cache_wt #(.ADDR_BITS(24), .INDEX_BITS(10), .OFFSET_BITS(OFF), .CACHE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .cache_reset(cache_reset),
    .l2_addr(l2_addr), .l2_data(l2_data), .l2_we(l2_we), .l2_start(l2_start),
    .l2_q(l2_q), .l2_done(l2_done),
    .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
    .sdc_q(sdc_q), .sdc_done(sdc_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } txn_t;

  txn_t        txq[$];
  logic [31:0] gold  [logic [31:0]];
  logic [31:0] sdram [logic [31:0]];
  bit          mvalid [1024];
  logic [31:0] mline  [1024];

  int          total = 0;
  int          bad = 0;
  bit          outstanding = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_q = 32'd0;
  logic [31:0] last_q;
  int          last_cyc, last_n;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] sd_rd(input logic [31:0] a);
    if (sdram.exists(a)) return sdram[a];
    return init_word(a);
  endfunction

  function automatic int line_idx(input logic [31:0] a);
    return int'((a >> OFF) & 32'h3FF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SDRAM responder: two-cycle latency, one-cycle done pulse
  initial begin : sdram_resp
    int lat;
    lat = 0;
    sdc_done = 1'b0;
    sdc_q = 32'd0;
    forever begin
      @(negedge clk);
      if (sdc_done) begin
        sdc_done = 1'b0;
        lat = 0;
        if (l2_addr < LIMIT) chk("sdc_start_gap", {31'b0, sdc_start}, 32'd0);
      end else if (sdc_start) begin
        lat++;
        if (lat == 2) begin
          txq.push_back('{sdc_addr, sdc_we, sdc_data});
          if (sdc_we) sdram[sdc_addr] = sdc_data;
          else sdc_q = sd_rd(sdc_addr);
          sdc_done = 1'b1;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // compare process: every done pulse must belong to a request and carry the model's read data
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (l2_done) begin
        if (!outstanding) chk("spurious_done", {31'b0, l2_done}, 32'd0);
        else if (!exp_we) chk("l2_q", l2_q, exp_q);
      end
    end
  end

  task automatic cpu_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int rst_at, input bit keep);
    int          cyc, n0, expn, li;
    bit          pass, hit;
    logic [31:0] base;
    txn_t        t;
    pass = a >= LIMIT;
    li   = line_idx(a);
    base = a & ~32'(LW - 1);
    hit  = !pass && mvalid[li] && (mline[li] == (a >> OFF));
    exp_we = w;
    exp_q  = gold_rd(a);
    outstanding = 1;
    n0 = txq.size();
    l2_addr = a; l2_data = d; l2_we = w; l2_start = 1'b1;
    if (pass) begin
      #1;
      chk("pt_sdc_addr", sdc_addr, a);
      chk("pt_sdc_data", sdc_data, d);
      chk("pt_sdc_we", {31'b0, sdc_we}, {31'b0, w});
      chk("pt_sdc_start", {31'b0, sdc_start}, 32'd1);
    end
    cyc = 0;
    do begin
      @(posedge clk);
      #2;
      cyc++;
      cache_reset = (rst_at > 0) && (cyc == rst_at);
    end while (!l2_done && cyc < 300);
    cache_reset = 1'b0;
    chk("l2_done_seen", {31'b0, l2_done}, 32'd1);
    if (pass) chk("pt_done_mirror", {31'b0, l2_done}, {31'b0, sdc_done});
    else begin
      chk("sdc_start_at_done", {31'b0, sdc_start}, 32'd0);
      chk("sdc_addr_at_done", sdc_addr, 32'd0);
    end
    last_q = l2_q;
    last_cyc = cyc;
    last_n = txq.size() - n0;
    if (!pass && !w && hit) chk("hit_latency", 32'(cyc), 32'd3);
    expn = (pass || w) ? 1 : (hit ? 0 : LW);
    chk("sdc_txn_count", 32'(last_n), 32'(expn));
    for (int i = 0; i < expn && n0 + i < txq.size(); i++) begin
      t = txq[n0 + i];
      chk("sdc_txn_addr", t.addr, (pass || w) ? a : base + 32'(i));
      chk("sdc_txn_we", {31'b0, t.we}, {31'b0, w});
      if (w) chk("sdc_txn_data", t.data, d);
    end
    if (w) gold[a] = d;
    if (rst_at > 0 && rst_at < cyc) begin
      for (int i = 0; i < 1024; i++) mvalid[i] = 0;
    end else if (!pass && !w && !hit) begin
      mvalid[li] = 1;
      mline[li]  = a >> OFF;
    end
    outstanding = 0;
    if (!keep) begin
      l2_start = 1'b0;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_cache_reset();
    cache_reset = 1'b1;
    @(posedge clk);
    #2;
    cache_reset = 1'b0;
    for (int i = 0; i < 1024; i++) mvalid[i] = 0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; cache_reset = 1'b0;
    l2_addr = 32'd0; l2_data = 32'd0; l2_we = 1'b0; l2_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_l2_done", {31'b0, l2_done}, 32'd0);
    chk("rst_l2_q", l2_q, 32'd0);
    chk("rst_sdc_start", {31'b0, sdc_start}, 32'd0);
    chk("rst_sdc_addr", sdc_addr, 32'd0);
    chk("rst_sdc_we", {31'b0, sdc_we}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #2;

    // 1: line fill then hit
    cpu_op(32'h0000_0100, 1'b0, 32'd0, 0, 0);
    chk("t1_word0", last_q, 32'h0100_C0DE);
    chk("t1_fill_words", 32'(last_n), 32'd4);
    chk("t1_last_fill_addr", txq[txq.size() - 1].addr, 32'h0000_0103);
    cpu_op(32'h0000_0100, 1'b0, 32'd0, 0, 0);
    chk("t1_hit_cycles", 32'(last_cyc), 32'd3);
    chk("t1_hit_no_sdc", 32'(last_n), 32'd0);

    // 2: write hit keeps the line valid and updated
    cpu_op(32'h0000_0101, 1'b1, 32'hDEAD_BEEF, 0, 0);
    cpu_op(32'h0000_0101, 1'b0, 32'd0, 0, 0);
    chk("t2_hit_word", last_q, 32'hDEAD_BEEF);
    chk("t2_hit_no_sdc", 32'(last_n), 32'd0);

    // 3: write miss does not allocate
    cpu_op(32'h0000_4000, 1'b1, 32'h1234_5678, 0, 0);
    cpu_op(32'h0000_4000, 1'b0, 32'd0, 0, 0);
    chk("t3_fill_after_wmiss", 32'(last_n), 32'd4);
    chk("t3_word", last_q, 32'h1234_5678);

    // 4: same index, different tag
    cpu_op(32'h0000_1100, 1'b0, 32'd0, 0, 0);
    chk("t4_conflict_fill", 32'(last_n), 32'd4);
    cpu_op(32'h0000_0100, 1'b0, 32'd0, 0, 0);
    chk("t4_evicted_miss", 32'(last_n), 32'd4);
    chk("t4_word", last_q, 32'h0100_C0DE);

    // 5: invalidate mid-fill and in idle
    cpu_op(32'h0000_0202, 1'b0, 32'd0, 6, 0);
    chk("t5_killed_word", last_q, 32'h0202_C0DE);
    cpu_op(32'h0000_0202, 1'b0, 32'd0, 0, 0);
    chk("t5_refill", 32'(last_n), 32'd4);
    cpu_op(32'h0000_0202, 1'b0, 32'd0, 0, 0);
    chk("t5_now_hit", 32'(last_n), 32'd0);
    pulse_cache_reset();
    cpu_op(32'h0000_0202, 1'b0, 32'd0, 0, 0);
    chk("t5_idle_inval_miss", 32'(last_n), 32'd4);

    // 6: passthrough, then cached read with the strobe still high
    cpu_op(32'h0080_0000, 1'b0, 32'h5555_AAAA, 0, 1);
    chk("t6_pt_word", last_q, 32'h0000_C0DE);
    cpu_op(32'h0000_0300, 1'b0, 32'd0, 0, 0);
    chk("t6_backtoback_fill", 32'(last_n), 32'd4);
    chk("t6_word", last_q, 32'h0300_C0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
